// File: rtl/rand_pkg.sv
// Shared types and the single-bit PRBS step (1 + x^14 + x^15) for the burst randomizer.
package rand_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PAD  = 2'd2
    } state_t;

    localparam int PRBS_LEN = 15;
    localparam int TAP_A    = 13;
    localparam int TAP_B    = 14;

    // Returns {next_v, fb}; fb is also the keystream bit for this step.
    function automatic logic [PRBS_LEN:0] prbs_step(input logic [PRBS_LEN-1:0] v);
        logic fb;
        fb = v[TAP_A] ^ v[TAP_B];
        return {v[PRBS_LEN-2:0], fb, fb};
    endfunction

endpackage

// File: rtl/prbs_unroll.sv
// Combinational W-step LFSR advance; keystream bit W-1 is the first step in time.
module prbs_unroll
    import rand_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [PRBS_LEN-1:0] v,
    output logic [PRBS_LEN-1:0] next_v,
    output logic [W-1:0]        keystream
);

    logic [PRBS_LEN-1:0] cur;
    logic [PRBS_LEN:0]   step;

    always_comb begin
        cur       = v;
        step      = '0;
        keystream = '0;
        for (int i = 0; i < W; i++) begin
            step             = prbs_step(cur);
            keystream[W-1-i] = step[0];
            cur              = step[PRBS_LEN:1];
        end
        next_v = cur;
    end

endmodule

// File: rtl/burst_randomizer.sv
// Burst-aware PRBS randomizer/derandomizer: per-burst seed and word count, W bits per clock.
// Optional RAND_PAD_EN: an early in_last pads the remaining burst with randomized all-ones words.
module burst_randomizer
    import rand_pkg::*;
#(
    parameter int W     = 8,
    parameter int LEN_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [PRBS_LEN-1:0] cfg_seed,
    input  logic [LEN_W-1:0]    cfg_len,
    input  logic [W-1:0]        in_data,
    input  logic                in_valid,
    input  logic                in_last,
    output logic                in_ready,
    output logic [W-1:0]        out_data,
    output logic                out_valid,
    output logic                out_last,
    input  logic                out_ready,
    output logic                busy
);

    state_t              state, state_nx;
    logic [PRBS_LEN-1:0] lfsr, lfsr_nx;
    logic [LEN_W-1:0]    cnt;
    logic [W-1:0]        keystream;
    logic                out_free, cfg_fire, in_fire, pad_fire, word_fire, final_word, go_pad;

    prbs_unroll #(.W(W)) u_unroll (
        .v         (lfsr),
        .next_v    (lfsr_nx),
        .keystream (keystream)
    );

    assign out_free   = !out_valid || out_ready;
    assign cfg_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign in_ready   = (state == RUN) && out_free;
    assign cfg_fire   = cfg_valid && cfg_ready;
    assign in_fire    = in_valid && in_ready;

`ifdef RAND_PAD_EN
    assign pad_fire   = (state == PAD) && out_free;
    assign go_pad     = in_fire && in_last && (cnt > LEN_W'(1));
`else
    logic unused_last;
    assign unused_last = in_last;
    assign pad_fire    = 1'b0;
    assign go_pad      = 1'b0;
`endif

    assign word_fire  = in_fire || pad_fire;
    assign final_word = word_fire && (cnt == LEN_W'(1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (cfg_fire && (cfg_len != '0)) state_nx = RUN;
            RUN: begin
                if (final_word)  state_nx = IDLE;
                else if (go_pad) state_nx = PAD;
            end
`ifdef RAND_PAD_EN
            PAD: if (final_word) state_nx = IDLE;
`endif
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            lfsr      <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state <= state_nx;
            if (cfg_fire) begin
                lfsr <= cfg_seed;
                cnt  <= cfg_len;
            end else if (word_fire) begin
                lfsr <= lfsr_nx;
                cnt  <= cnt - LEN_W'(1);
            end
            // Single output register; holds data and last while stalled.
            if (word_fire) begin
                out_valid <= 1'b1;
                out_data  <= (pad_fire ? {W{1'b1}} : in_data) ^ keystream;
                out_last  <= (cnt == LEN_W'(1));
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/burst_randomizer.md
# burst_randomizer

Parametrised, burst-aware PRBS randomizer (1 + x^14 + x^15) for the OFDM transmit chain, placed between the MAC burst source and the FEC encoder. Each burst is configured with its own seed and word count. The LFSR is reloaded automatically at burst start, and the block processes W bits per clock with full valid/ready flow control on both sides. Because XOR randomization is self-inverse, the same block is used as the derandomizer in the receive chain.

## Interface
- W, default 8: bits per word per clock, 1..64. Bit W-1 of a word is the first bit in time.
- LEN_W, default 16: width of the burst word-count field.

Ports (reset is asynchronous, active-high; clock is clk):
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cfg_valid  in  1  burst descriptor valid
- cfg_ready  out  1  descriptor accepted when cfg_valid & cfg_ready
- cfg_seed  in  15  LFSR initial vector; bit 14 is the stage that feeds back first
- cfg_len  in  LEN_W  burst length in W-bit words
- in_data  in  W  payload word
- in_valid  in  1  payload valid
- in_last  in  1  last payload word (used only with RAND_PAD_EN)
- in_ready  out  1  payload accepted when in_valid & in_ready
- out_data  out  W  randomized word
- out_valid  out  1  output valid
- out_last  out  1  marks the final word of the burst
- out_ready  in  1  downstream ready
- busy  out  1  a burst is in progress (state other than IDLE)

## Operation
- LFSR step, applied per bit:
  - fb = v[13] ^ v[14]
  - out_bit = in_bit ^ fb
  - v <= {v[13:0], fb}
- W steps are unrolled combinationally per word. Output bit W-1 uses the first fb.
- The state register holds the LFSR state after the last accepted word.
- FSM states:
  - IDLE: cfg_ready=1. On descriptor accept, load v=cfg_seed and cnt=cfg_len. Go to RUN, or go to IDLE with no output if cfg_len==0.
  - RUN: accept a payload word, emit it randomized, and decrement cnt. After the word where cnt reaches 0, go to IDLE.
  - PAD: exists only with RAND_PAD_EN; behaviour is described under Configuration.
- in_ready = (state==RUN) & (!out_valid | out_ready). There is a single output register.
- out_last = 1 on the word that completes cfg_len.
- After cnt reaches 0, in_ready stays 0 until the next descriptor is accepted. Surplus payload is never consumed.
- cfg_ready is 0 in RUN and PAD. A new descriptor may be accepted in the cycle after the final word is loaded into the output register, even while that word is still stalled at the output.
- cfg_seed==0 is legal. The LFSR stays at 0, so out_data = in_data.
- Reset at any point, including mid-burst, aborts the burst. No partial-burst state survives.

## Timing
- Reset values:
  - cfg_ready=1
  - in_ready=0
  - out_valid=0
  - out_data=0
  - out_last=0
  - busy=0
  - LFSR=0
  - cnt=0
  - state=IDLE
- Latency is 1 cycle from input accept to out_valid.
- With out_ready held at 1, throughput is 1 word per clock.
- Descriptor accept to the first possible in_ready=1 is 1 cycle.
- While out_valid=1 and out_ready=0, out_data and out_last hold stable.
- All outputs are registered, except in_ready, which is combinational from state, out_valid and out_ready.

## Configuration
- RAND_PAD_EN defined:
  - If a word with in_last=1 is accepted while cnt > 1, go to PAD.
  - PAD emits randomized all-ones words ({W{1'b1}} ^ PRBS) at 1 word per clock, subject to out_ready, until cnt reaches 0. The final pad word carries out_last.
  - in_ready=0 in PAD.
  - If in_last arrives exactly on the final word, there is no PAD.
- RAND_PAD_EN undefined:
  - in_last is ignored and the PAD state is not built.
  - A burst ends only on count.

## Structure
- Package rand_pkg holds:
  - the state enum (IDLE/RUN/PAD)
  - PRBS_LEN=15
  - the tap constants (13, 14)
  - the function prbs_step(v) returning the {next_v, fb} pair
- One sub-module, prbs_unroll: a combinational W-step LFSR advance that outputs next_v and a W-bit keystream.
- The top level contains the FSM, counter and output register.

## Test plan
- W=8, seed 15'h7FFF, cfg_len=2, in_data 8'h00, 8'h00 -> out_data 8'h00, 8'h02; out_last on the second word; busy returns to 0.
- Round trip: random 64-word burst, seed 15'h3715, fed through two instances -> output equals input bit-exact; also repeat with W=1 and W=16 against a bit-serial model.
- Backpressure: toggle out_ready randomly -> no word lost or duplicated; out_data stable while stalled; in_ready=0 after cnt reaches 0 even with surplus in_valid.
- cfg_len=0 -> no output; cfg_ready=1 again the next cycle. cfg_seed=0 -> out_data equals in_data.
- RAND_PAD_EN, cfg_len=4, in_last on word 2 -> 2 pad words = 8'hFF ^ PRBS; out_last on word 4; in_ready=0 during PAD.
- Assert reset mid-burst -> all outputs at reset values immediately. A new descriptor then produces output identical to a fresh-start model.
